// File: rtl/acc_job_scheduler_if.sv
// ---------------------------------------------------------------------------
// acc_job_scheduler_if
//   Bundles the job-post handshake, the accelerator start/idle/done handshake
//   and the scheduler status outputs into one interface.
//
//   Modports
//     slave  : the scheduler itself (acc_job_scheduler)
//     master : the surrounding world, i.e. the MMIO decoder posting jobs plus
//              the accelerator answering ap_start with ap_idle/ap_done
//
//   Signals
//     job_valid   job push request                  (master -> slave)
//     job_code    3-bit one-hot job code            (master -> slave)
//     job_ready   queue can accept a job            (slave  -> master)
//     ap_start    one-hot start to accelerator      (slave  -> master)
//     ap_idle     accelerator idle                  (master -> slave)
//     ap_done     one-hot done pulse                (master -> slave)
//     busy        job in flight or queue non-empty  (slave  -> master)
//     cur_job     code of job in flight, 0 if none  (slave  -> master)
//     q_level     queued jobs, excluding in flight  (slave  -> master)
//     done_pulse  one-cycle retire pulse            (slave  -> master)
//     done_cnt    retired-job counter, wraps        (slave  -> master)
//     err         sticky error flag                 (slave  -> master)
// ---------------------------------------------------------------------------
interface acc_job_scheduler_if #(
    parameter int QDEPTH = 4,
    parameter int CNT_W  = 16
);
    localparam int QW = $clog2(QDEPTH);

    logic             job_valid;
    logic [2:0]       job_code;
    logic             job_ready;
    logic [2:0]       ap_start;
    logic             ap_idle;
    logic [2:0]       ap_done;
    logic             busy;
    logic [2:0]       cur_job;
    logic [QW:0]      q_level;
    logic             done_pulse;
    logic [CNT_W-1:0] done_cnt;
    logic             err;

    modport slave (
        input  job_valid, job_code, ap_idle, ap_done,
        output job_ready, ap_start, busy, cur_job, q_level,
               done_pulse, done_cnt, err
    );

    modport master (
        output job_valid, job_code, ap_idle, ap_done,
        input  job_ready, ap_start, busy, cur_job, q_level,
               done_pulse, done_cnt, err
    );
endinterface

// File: rtl/acc_job_scheduler.sv
// ---------------------------------------------------------------------------
// acc_job_scheduler
//   Queues FIR / MATMUL / SORTING jobs posted from the MMIO register block and
//   issues them one at a time to the accelerator through its one-hot
//   ap_start / ap_idle / ap_done handshake. Tracks the job in flight, counts
//   retired jobs and raises a one-cycle done_pulse per retirement.
//
//   Ports
//     clk   system clock
//     rst   asynchronous reset, active-high
//     bus   acc_job_scheduler_if.slave (job push, accelerator handshake,
//           status: busy, cur_job, q_level, done_pulse, done_cnt, err)
//
//   Parameters
//     QDEPTH  job queue entries (power of 2, >= 2)
//     CNT_W   done_cnt width
//     TO_W    watchdog width, used only with ACC_SCHED_TIMEOUT_EN
//
//   Build option
//     ACC_SCHED_TIMEOUT_EN  when defined, a TO_W-bit watchdog runs while a job
//                           is in RUN/DRAIN; expiry sets err and abandons the
//                           job without counting it. Undefined: no watchdog.
// ---------------------------------------------------------------------------
module acc_job_scheduler #(
    parameter int QDEPTH = 4,
    parameter int CNT_W  = 16,
    parameter int TO_W   = 20
) (
    input  logic               clk,
    input  logic               rst,
    acc_job_scheduler_if.slave bus
);
    localparam int          QW    = $clog2(QDEPTH);
    localparam logic [QW:0] QFULL = (QW+1)'(QDEPTH);

    // Elaboration-time parameter sanity checks.
    if (QDEPTH < 2 || (QDEPTH & (QDEPTH - 1)) != 0) begin : g_bad_qdepth
        $error("acc_job_scheduler: QDEPTH must be a power of 2 and >= 2");
    end
    if (TO_W < 2) begin : g_bad_to_w
        $error("acc_job_scheduler: TO_W must be >= 2");
    end

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RUN, S_DRAIN} state_t;

    state_t           state;
    logic [2:0]       q_mem [QDEPTH];
    logic [QW-1:0]    wr_ptr;
    logic [QW-1:0]    rd_ptr;
    logic [QW:0]      q_cnt;
    logic [2:0]       ap_start_r;
    logic [2:0]       cur_job_r;
    logic             done_pulse_r;
    logic [CNT_W-1:0] done_cnt_r;
    logic             err_r;

    function automatic logic is_onehot3(input logic [2:0] c);
        return (c == 3'b001) || (c == 3'b010) || (c == 3'b100);
    endfunction

    logic q_full, q_empty, push_acc, push_ok, pop;

    assign q_full   = (q_cnt == QFULL);
    assign q_empty  = (q_cnt == '0);
    // Handshake completes for any code; only one-hot codes enter the queue.
    assign push_acc = bus.job_valid && !q_full;
    assign push_ok  = push_acc && is_onehot3(bus.job_code);
    assign pop      = (state == S_IDLE) && !q_empty && bus.ap_idle;

`ifdef ACC_SCHED_TIMEOUT_EN
    logic [TO_W-1:0] wd;
    logic            wd_expire;
    // Fires on the cycle whose increment would make the counter all-ones.
    assign wd_expire = (wd == {{(TO_W-1){1'b1}}, 1'b0});
`endif

    // Queue storage carries no reset; validity is tracked by q_cnt.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            q_mem[wr_ptr] <= bus.job_code;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            q_cnt  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   q_cnt <= q_cnt + 1'b1;
                2'b01:   q_cnt <= q_cnt - 1'b1;
                default: q_cnt <= q_cnt;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            ap_start_r   <= '0;
            cur_job_r    <= '0;
            done_pulse_r <= 1'b0;
            done_cnt_r   <= '0;
            err_r        <= 1'b0;
`ifdef ACC_SCHED_TIMEOUT_EN
            wd           <= '0;
`endif
        end else begin
            done_pulse_r <= 1'b0;
            if (push_acc && !is_onehot3(bus.job_code)) begin
                err_r <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        cur_job_r  <= q_mem[rd_ptr];
                        ap_start_r <= q_mem[rd_ptr];
                        state      <= S_ISSUE;
`ifdef ACC_SCHED_TIMEOUT_EN
                        wd         <= '0;
`endif
                    end
                end
                S_ISSUE: begin
                    ap_start_r <= '0;
                    state      <= S_RUN;
                end
                S_RUN, S_DRAIN: begin
`ifdef ACC_SCHED_TIMEOUT_EN
                    wd <= wd + 1'b1;
                    if (wd_expire) begin
                        // Abandon the job; the queue is kept intact.
                        state     <= S_IDLE;
                        cur_job_r <= '0;
                        err_r     <= 1'b1;
                    end else
`endif
                    if (state == S_RUN) begin
                        if (bus.ap_done == cur_job_r) begin
                            state <= S_DRAIN;
                        end else if (bus.ap_done != '0) begin
                            // Done for a job that is not in flight.
                            err_r <= 1'b1;
                        end
                    end else if (bus.ap_idle) begin
                        state        <= S_IDLE;
                        done_pulse_r <= 1'b1;
                        done_cnt_r   <= done_cnt_r + 1'b1;
                        cur_job_r    <= '0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.job_ready  = !q_full;
    assign bus.ap_start   = ap_start_r;
    assign bus.busy       = (state != S_IDLE) || !q_empty;
    assign bus.cur_job    = cur_job_r;
    assign bus.q_level    = q_cnt;
    assign bus.done_pulse = done_pulse_r;
    assign bus.done_cnt   = done_cnt_r;
    assign bus.err        = err_r;
endmodule

// File: tb/tb_acc_job_scheduler.sv
// ---------------------------------------------------------------------------
// tb_acc_job_scheduler
//   Directed bench for acc_job_scheduler. The bench plays both the MMIO job
//   poster and the accelerator. Each accepted legal push queues its expected
//   ap_start code and its expected done_cnt value; a monitor process pops and
//   compares whenever ap_start is non-zero or done_pulse is high.
// ---------------------------------------------------------------------------
module tb_acc_job_scheduler;
    logic clk = 1'b0;
    logic rst = 1'b1;

    acc_job_scheduler_if #(.QDEPTH(4), .CNT_W(16)) bus ();

    acc_job_scheduler #(.QDEPTH(4), .CNT_W(16), .TO_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_bad = 0;
    int          model_cnt = 0;
    logic [2:0]  exp_start [$];
    logic [31:0] exp_done  [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit legal(input logic [2:0] c);
        return (c == 3'b001) || (c == 3'b010) || (c == 3'b100);
    endfunction

    // Drive one push for a cycle; exp_acc is the hand-computed job_ready.
    task automatic push(input logic [2:0] code, input bit exp_acc);
        check("job_ready", 32'(bus.job_ready), 32'(exp_acc));
        if (exp_acc && legal(code)) begin
            exp_start.push_back(code);
            model_cnt++;
            exp_done.push_back(32'(model_cnt));
        end
        bus.job_valid = 1'b1;
        bus.job_code  = code;
        @(negedge clk);
        bus.job_valid = 1'b0;
        bus.job_code  = 3'b000;
    endtask

    // Returns on the negedge where ap_start is non-zero, then drops ap_idle.
    task automatic wait_start(input int limit);
        bit seen = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (bus.ap_start != 3'b000) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        n_vec++;
        if (!seen) begin
            n_bad++;
            $display("FAIL start_timeout: no ap_start within %0d cycles", limit);
        end
        bus.ap_idle = 1'b0;
    endtask

    task automatic wait_pulse(input int limit);
        bit seen = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (bus.done_pulse) begin
                seen = 1'b1;
                break;
            end
        end
        n_vec++;
        if (!seen) begin
            n_bad++;
            $display("FAIL pulse_timeout: no done_pulse within %0d cycles", limit);
        end
    endtask

    // Accelerator finishes the job in RUN: done pulse, drain, then idle.
    task automatic finish_job(input logic [2:0] code, input int drain);
        @(negedge clk);
        bus.ap_done = code;
        @(negedge clk);
        bus.ap_done = 3'b000;
        repeat (drain) @(negedge clk);
        bus.ap_idle = 1'b1;
        wait_pulse(drain + 20);
    endtask

    task automatic run_job(input logic [2:0] code, input int drain);
        wait_start(20);
        finish_job(code, drain);
    endtask

    // Scoreboard monitor
    initial begin
        logic [2:0]  es;
        logic [31:0] ed;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.ap_start != 3'b000) begin
                    n_vec++;
                    if (exp_start.size() == 0) begin
                        n_bad++;
                        $display("FAIL sb_start: got %b with no job expected", bus.ap_start);
                    end else begin
                        es = exp_start.pop_front();
                        if (bus.ap_start !== es) begin
                            n_bad++;
                            $display("FAIL sb_start: got %b expected %b", bus.ap_start, es);
                        end
                    end
                end
                if (bus.done_pulse) begin
                    n_vec++;
                    if (exp_done.size() == 0) begin
                        n_bad++;
                        $display("FAIL sb_done: pulse with done_cnt %0d, none expected", bus.done_cnt);
                    end else begin
                        ed = exp_done.pop_front();
                        if (32'(bus.done_cnt) !== ed) begin
                            n_bad++;
                            $display("FAIL sb_done: done_cnt %0d expected %0d", bus.done_cnt, ed);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.job_valid = 1'b0;
        bus.job_code  = 3'b000;
        bus.ap_idle   = 1'b1;
        bus.ap_done   = 3'b000;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_ap_start",   32'(bus.ap_start),   0);
        check("rst_cur_job",    32'(bus.cur_job),    0);
        check("rst_busy",       32'(bus.busy),       0);
        check("rst_q_level",    32'(bus.q_level),    0);
        check("rst_job_ready",  32'(bus.job_ready),  1);
        check("rst_done_pulse", 32'(bus.done_pulse), 0);
        check("rst_done_cnt",   32'(bus.done_cnt),   0);
        check("rst_err",        32'(bus.err),        0);
        rst = 1'b0;
        @(negedge clk);

        // Single FIR job: start two cycles after push, one cycle wide
        push(3'b001, 1'b1);
        check("t2_q_level", 32'(bus.q_level), 1);
        check("t2_start_early", 32'(bus.ap_start), 0);
        @(negedge clk);
        check("t2_start", 32'(bus.ap_start), 1);
        check("t2_cur_job", 32'(bus.cur_job), 1);
        bus.ap_idle = 1'b0;
        @(negedge clk);
        check("t2_start_width", 32'(bus.ap_start), 0);
        finish_job(3'b001, 64);
        check("t2_done_cnt", 32'(bus.done_cnt), 1);
        check("t2_busy", 32'(bus.busy), 0);
        check("t2_cur_job_clr", 32'(bus.cur_job), 0);
        @(negedge clk);
        check("t2_pulse_width", 32'(bus.done_pulse), 0);

        // Illegal code: consumed, not queued, err set
        push(3'b011, 1'b1);
        check("t4_err", 32'(bus.err), 1);
        check("t4_q_level", 32'(bus.q_level), 0);
        repeat (3) @(negedge clk);
        check("t4_no_start", 32'(bus.ap_start), 0);
        check("t4_busy", 32'(bus.busy), 0);

        // Asynchronous reset in the middle of RUN
        push(3'b100, 1'b1);
        wait_start(20);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("t1_ap_start", 32'(bus.ap_start), 0);
        check("t1_cur_job",  32'(bus.cur_job),  0);
        check("t1_busy",     32'(bus.busy),     0);
        check("t1_done_cnt", 32'(bus.done_cnt), 0);
        check("t1_err",      32'(bus.err),      0);
        exp_start.delete();
        exp_done.delete();
        model_cnt = 0;
        bus.ap_idle = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("t1_q_level", 32'(bus.q_level), 0);

        // Queue fill while a job runs, in-order issue
        push(3'b001, 1'b1);
        wait_start(20);
        push(3'b010, 1'b1);
        push(3'b100, 1'b1);
        push(3'b001, 1'b1);
        push(3'b010, 1'b1);
        check("t3_q_full", 32'(bus.q_level), 4);
        push(3'b100, 1'b0);
        check("t3_q_kept", 32'(bus.q_level), 4);
        finish_job(3'b001, 2);
        run_job(3'b010, 3);
        run_job(3'b100, 1);
        run_job(3'b001, 2);
        run_job(3'b010, 4);
        check("t3_done_cnt", 32'(bus.done_cnt), 5);
        check("t3_busy", 32'(bus.busy), 0);
        check("t3_err", 32'(bus.err), 0);

        // ap_idle gating
        bus.ap_idle = 1'b0;
        push(3'b100, 1'b1);
        for (int i = 0; i < 10; i++) begin
            check("t5_gated", 32'(bus.ap_start), 0);
            @(negedge clk);
        end
        check("t5_q_level", 32'(bus.q_level), 1);
        check("t5_busy", 32'(bus.busy), 1);
        bus.ap_idle = 1'b1;
        @(negedge clk);
        check("t5_start", 32'(bus.ap_start), 4);
        bus.ap_idle = 1'b0;
        finish_job(3'b100, 3);
        check("t5_done_cnt", 32'(bus.done_cnt), 6);

        // Withheld ap_done
        push(3'b010, 1'b1);
        wait_start(20);
`ifdef ACC_SCHED_TIMEOUT_EN
        repeat (15) @(negedge clk);
        check("t6_still_run", 32'(bus.cur_job), 2);
        @(negedge clk);
        check("t6_abandoned", 32'(bus.cur_job), 0);
        check("t6_err", 32'(bus.err), 1);
        check("t6_done_cnt", 32'(bus.done_cnt), 6);
        void'(exp_done.pop_back());
        model_cnt--;
        bus.ap_idle = 1'b1;
        @(negedge clk);
        check("t6_busy", 32'(bus.busy), 0);
`else
        repeat (40) @(negedge clk);
        check("t6_cur_job", 32'(bus.cur_job), 2);
        check("t6_busy", 32'(bus.busy), 1);
        check("t6_err", 32'(bus.err), 0);
        finish_job(3'b010, 1);
        check("t6_done_cnt", 32'(bus.done_cnt), 7);
`endif

        // ap_done for a different job: ignored, err set
        push(3'b001, 1'b1);
        wait_start(20);
        @(negedge clk);
        bus.ap_done = 3'b010;
        @(negedge clk);
        bus.ap_done = 3'b000;
        bus.ap_idle = 1'b1;
        repeat (3) @(negedge clk);
        check("t7_err", 32'(bus.err), 1);
        check("t7_cur_job", 32'(bus.cur_job), 1);
        check("t7_done_cnt", 32'(bus.done_cnt), 32'(model_cnt - 1));
        bus.ap_idle = 1'b0;
        finish_job(3'b001, 2);
        check("t7_final_cnt", 32'(bus.done_cnt), 32'(model_cnt));

        repeat (3) @(negedge clk);
        check("end_busy", 32'(bus.busy), 0);
        check("end_sb_start_left", 32'(exp_start.size()), 0);
        check("end_sb_done_left", 32'(exp_done.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
